// File: rtl/mem_byte_streamer.sv
// mem_byte_streamer
//
// Purpose:
//   Walks a fixed word region of data memory through its secondary,
//   combinational read port and emits the words as a ready/valid byte
//   stream. Byte lane 0 (bits [7:0]) goes out first, matching the CPU's
//   load-byte lane mapping. The block also drives the memory's secondary
//   write port, which memory stores into word 510 on every clock. Software
//   polls that word with lw to see the streamer's status.
//
// Parameters:
//   BASE_WORD    first word index read (a word index, not a byte address)
//   NUM_WORDS    words per frame; at least 1, BASE_WORD+NUM_WORDS <= 510
//
// Ports:
//   i_clk         single clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       begin a frame (only honoured in IDLE)
//   i_ext_status  external status bits mirrored into the mailbox
//   o_rd_addr     word index to memory Address1
//   i_rd_data     memory Read_data1 (combinational from o_rd_addr)
//   o_wr_mbox     registered mailbox word to memory Write_data1
//   o_byte_out    stream byte
//   o_byte_valid  o_byte_out is valid
//   i_byte_ready  sink accepts the byte this cycle
//   o_busy        high whenever the FSM is not IDLE
//   o_done        one-cycle pulse at frame end

module mem_byte_streamer #(
  parameter int BASE_WORD = 0,
  parameter int NUM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_ext_status,
  output logic [31:0] o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_wr_mbox,
  output logic [7:0]  o_byte_out,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [8:0]  LAST_IDX  = 9'(NUM_WORDS - 1);
  localparam logic [31:0] BASE_ADDR = 32'(BASE_WORD);

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_idx;
  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [31:0] r_addr_hold;
  logic [7:0]  r_frame_count;
  logic        r_done_seen;
  logic [31:0] r_wr_mbox;
  logic [31:0] w_fetch_addr;

  // Word address presented to memory while fetching. The read port is
  // combinational, so the address must be live in the same cycle that
  // Read_data1 is captured.
  assign w_fetch_addr = BASE_ADDR + {23'b0, r_idx};

  // Current lane of the captured word. The word and lane registers only
  // change on a fetch or an accepted byte, so the byte stays stable while
  // the sink stalls.
  assign o_byte_out = r_word[{r_lane, 3'b000} +: 8];

  assign o_wr_mbox = r_wr_mbox;

  // State register. Reset drops straight back to IDLE, which abandons any
  // frame in flight without a done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode. The address port shows the live fetch
  // address only in FETCH and otherwise repeats the last fetched address.
  // A frame ends on the accepted byte from lane 3 of the last word.
  always_comb begin
    w_state_next = r_state;
    o_rd_addr    = r_addr_hold;
    o_byte_valid = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        o_rd_addr    = w_fetch_addr;
        w_state_next = S_STREAM;
      end
      S_STREAM: begin
        o_byte_valid = 1'b1;
        if (i_byte_ready && (r_lane == 2'd3)) begin
          w_state_next = (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath. The mailbox is refreshed every cycle from the current status
  // registers, so it trails the FSM by one clock. Memory then adds another
  // clock before the value lands in word 510. done_seen stays set after a
  // frame until software (via start) begins the next one. The word index
  // only advances once all four lanes of the current word are accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx         <= 9'd0;
      r_lane        <= 2'd0;
      r_word        <= 32'd0;
      r_addr_hold   <= BASE_ADDR;
      r_frame_count <= 8'd0;
      r_done_seen   <= 1'b0;
      r_wr_mbox     <= 32'd0;
    end else begin
      r_wr_mbox <= {i_ext_status, r_frame_count, 6'b0, r_done_seen, o_busy};
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx       <= 9'd0;
            r_done_seen <= 1'b0;
          end
        end
        S_FETCH: begin
          r_word      <= i_rd_data;
          r_lane      <= 2'd0;
          r_addr_hold <= w_fetch_addr;
        end
        S_STREAM: begin
          if (i_byte_ready) begin
            if (r_lane != 2'd3) begin
              r_lane <= r_lane + 2'd1;
            end else if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 9'd1;
            end
          end
        end
        S_DONE: begin
          r_frame_count <= r_frame_count + 8'd1;
          r_done_seen   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_streamer.sv
// Testbench for mem_byte_streamer.
//
// Two instances share one behavioural data memory. dut1 (BASE_WORD=0,
// NUM_WORDS=2) streams words 0..1 and owns the mailbox word 510. dut2
// (BASE_WORD=100, NUM_WORDS=1) covers the offset base and the single-word
// frame. Directed stimulus pushes hand-computed expected bytes and done
// pulses into per-instance queues. Independent monitors pop those queues
// whenever a byte transfer or done pulse is presented.

module tb_mem_byte_streamer;

  typedef struct packed {
    logic [7:0] data;
    int         cyc;
  } expByte_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start2;
  logic [15:0] extStatus;
  logic        byteReady;
  logic        byteReady2;

  logic [31:0] rdAddr;
  logic [31:0] rdData;
  logic [31:0] wrMbox;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        busy;
  logic        done;

  logic [31:0] rdAddr2;
  logic [31:0] rdData2;
  logic [31:0] wrMbox2;
  logic [7:0]  byteOut2;
  logic        byteValid2;
  logic        busy2;
  logic        done2;

  logic [31:0] mem [0:511];
  logic [31:0] mem510 = 32'd0;

  int cycCnt = 0;
  int nChecks = 0;
  int nPassed = 0;

  expByte_t expQ[$];
  expByte_t expQ2[$];
  int       expDoneQ[$];
  int       expDoneQ2[$];
  expByte_t popped1;
  expByte_t popped2;
  int       doneCyc1;
  int       doneCyc2;

  logic [7:0] bytesA [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] bytesB [0:3] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  mem_byte_streamer #(.BASE_WORD(0), .NUM_WORDS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ext_status(extStatus),
    .o_rd_addr(rdAddr), .i_rd_data(rdData), .o_wr_mbox(wrMbox),
    .o_byte_out(byteOut), .o_byte_valid(byteValid), .i_byte_ready(byteReady),
    .o_busy(busy), .o_done(done)
  );

  mem_byte_streamer #(.BASE_WORD(100), .NUM_WORDS(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_ext_status(extStatus),
    .o_rd_addr(rdAddr2), .i_rd_data(rdData2), .o_wr_mbox(wrMbox2),
    .o_byte_out(byteOut2), .o_byte_valid(byteValid2), .i_byte_ready(byteReady2),
    .o_busy(busy2), .o_done(done2)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter. At a falling edge it equals the number of the cycle
  // in progress.
  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Memory model: combinational secondary read port, and word 510 written
  // from dut1's mailbox on every clock.
  assign rdData  = (rdAddr[8:0] == 9'd510) ? mem510 : mem[rdAddr[8:0]];
  assign rdData2 = (rdAddr2[8:0] == 9'd510) ? mem510 : mem[rdAddr2[8:0]];
  always @(posedge clk) mem510 <= wrMbox;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one start pulse. The next rising edge is edge 0, and the current
  // cycle number is returned as the frame base. mode 0 pushes a full frame
  // untimed, mode 1 pushes a full frame with exact cycles, and mode 2 pushes
  // only the first three bytes with no done (the frame will be reset).
  task automatic applyStimulus(input int dutSel, input int mode, output int base);
    @(posedge clk);
    #1;
    base = cycCnt;
    if (dutSel == 1) begin
      start = 1'b1;
      for (int k = 0; k < ((mode == 2) ? 3 : 8); k++) begin
        expQ.push_back('{data: bytesA[k], cyc: (mode == 1) ? (base + 2 + k + (k / 4)) : -1});
      end
      if (mode != 2) expDoneQ.push_back((mode == 1) ? base + 11 : -1);
    end else begin
      start2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
        expQ2.push_back('{data: bytesB[k], cyc: (mode == 1) ? (base + 2 + k) : -1});
      end
      expDoneQ2.push_back((mode == 1) ? base + 6 : -1);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Advances to the falling edge of the given cycle.
  task automatic waitCycle(input int target);
    do @(negedge clk); while (cycCnt < target);
  endtask

  // Waits, with a cycle budget, until every expected done pulse is seen.
  task automatic waitFrameDone(input int dutSel, input int budget);
    int n = 0;
    while ((((dutSel == 1) ? expDoneQ.size() : expDoneQ2.size()) != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      nChecks++;
      $display("[TB] FAIL dut%0d frame timeout: done not seen within %0d cycles", dutSel, budget);
    end
  endtask

  // dut1 monitor: each presented transfer must match the queue head, in
  // order and (where timed) in the exact cycle. Done pulses are matched
  // the same way.
  always @(negedge clk) begin
    if (!rst) begin
      if (byteValid && byteReady) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL dut1 extra byte: got 0x%02h, expected no transfer", byteOut);
        end else begin
          popped1 = expQ.pop_front();
          checkOutput("dut1 byte", 32'(byteOut), 32'(popped1.data));
          if (popped1.cyc >= 0) checkOutput("dut1 byte cycle", cycCnt, popped1.cyc);
        end
      end
      if (done) begin
        if (expDoneQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL dut1 extra done: got pulse at cycle %0d, expected none", cycCnt);
        end else begin
          doneCyc1 = expDoneQ.pop_front();
          if (doneCyc1 >= 0) checkOutput("dut1 done cycle", cycCnt, doneCyc1);
        end
      end
    end
  end

  // dut2 monitor, same rules as the dut1 monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (byteValid2 && byteReady2) begin
        if (expQ2.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL dut2 extra byte: got 0x%02h, expected no transfer", byteOut2);
        end else begin
          popped2 = expQ2.pop_front();
          checkOutput("dut2 byte", 32'(byteOut2), 32'(popped2.data));
          if (popped2.cyc >= 0) checkOutput("dut2 byte cycle", cycCnt, popped2.cyc);
        end
      end
      if (done2) begin
        if (expDoneQ2.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL dut2 extra done: got pulse at cycle %0d, expected none", cycCnt);
        end else begin
          doneCyc2 = expDoneQ2.pop_front();
          if (doneCyc2 >= 0) checkOutput("dut2 done cycle", cycCnt, doneCyc2);
        end
      end
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int base;
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[0]   = 32'h4433_2211;
    mem[1]   = 32'h8877_6655;
    mem[100] = 32'hDEAD_BEEF;
    rst        = 1'b1;
    start      = 1'b0;
    start2     = 1'b0;
    extStatus  = 16'h0000;
    byteReady  = 1'b1;
    byteReady2 = 1'b1;

    $display("[TB] reset values");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rd_addr", rdAddr, 32'd0);
    checkOutput("reset wr_mbox", wrMbox, 32'd0);
    checkOutput("reset byte_out", 32'(byteOut), 32'd0);
    checkOutput("reset valid/busy/done", {29'd0, byteValid, busy, done}, 32'd0);
    checkOutput("reset dut2 rd_addr", rdAddr2, 32'd100);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset mid-frame after three bytes");
    applyStimulus(1, 2, base);
    waitCycle(base + 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset valid/busy/done", {29'd0, byteValid, busy, done}, 32'd0);
    checkOutput("midreset byte_out", 32'(byteOut), 32'd0);
    checkOutput("midreset rd_addr", rdAddr, 32'd0);
    checkOutput("midreset wr_mbox", wrMbox, 32'd0);
    checkOutput("midreset bytes consumed", expQ.size(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    extStatus = 16'hA5A5;

    $display("[TB] timed two-word frame with mailbox");
    applyStimulus(1, 1, base);
    checkOutput("fetch0 rd_addr", rdAddr, 32'd0);
    checkOutput("fetch busy", 32'(busy), 32'd1);
    waitCycle(base + 4);
    checkOutput("busy wr_mbox", wrMbox, 32'hA5A5_0001);
    checkOutput("busy mem510", mem510, 32'hA5A5_0001);
    waitCycle(base + 6);
    checkOutput("fetch1 rd_addr", rdAddr, 32'd1);
    waitCycle(base + 12);
    checkOutput("after done busy", 32'(busy), 32'd0);
    checkOutput("after done rd_addr hold", rdAddr, 32'd1);
    waitCycle(base + 13);
    checkOutput("done wr_mbox", wrMbox, 32'hA5A5_0102);
    checkOutput("done mem510 early", mem510, 32'hA5A5_0001);
    waitCycle(base + 14);
    checkOutput("done mem510", mem510, 32'hA5A5_0102);
    waitFrameDone(1, 50);

    $display("[TB] backpressure on lane 2");
    applyStimulus(1, 0, base);
    waitCycle(base + 3);
    @(posedge clk);
    #1;
    byteReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall byte_out", 32'(byteOut), 32'h33);
      checkOutput("stall valid", 32'(byteValid), 32'd1);
    end
    @(posedge clk);
    #1;
    byteReady = 1'b1;
    waitFrameDone(1, 50);

    $display("[TB] ready toggling every cycle");
    applyStimulus(1, 0, base);
    n = 0;
    while ((expDoneQ.size() != 0) && (n < 100)) begin
      @(posedge clk);
      #1;
      byteReady = ~byteReady;
      n++;
    end
    byteReady = 1'b1;
    if (n >= 100) begin
      nChecks++;
      $display("[TB] FAIL toggle frame timeout: done not seen within 100 cycles");
    end

    $display("[TB] start ignored during STREAM and DONE");
    applyStimulus(1, 0, base);
    waitCycle(base + 4);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitCycle(base + 10);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("no extra frame busy", 32'(busy), 32'd0);
    checkOutput("no pending done", expDoneQ.size(), 32'd0);
    checkOutput("frame count 4", wrMbox, 32'hA5A5_0402);

    $display("[TB] frame counter wrap");
    for (int f = 5; f <= 256; f++) begin
      applyStimulus(1, 0, base);
      waitFrameDone(1, 50);
      if (f == 255) begin
        waitCycle(base + 13);
        checkOutput("frame count 255", wrMbox, 32'hA5A5_FF02);
      end
    end
    waitCycle(base + 13);
    checkOutput("frame count wrap", wrMbox, 32'hA5A5_0002);

    $display("[TB] base 100, single word");
    applyStimulus(2, 1, base);
    checkOutput("dut2 fetch rd_addr", rdAddr2, 32'd100);
    waitFrameDone(2, 50);
    waitCycle(base + 8);
    checkOutput("dut2 rd_addr hold", rdAddr2, 32'd100);
    checkOutput("dut2 idle busy", 32'(busy2), 32'd0);

    repeat (5) @(negedge clk);
    checkOutput("dut1 leftover bytes", expQ.size(), 32'd0);
    checkOutput("dut2 leftover bytes", expQ2.size(), 32'd0);
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
